// File: rtl/crossbar_arbiter_pkg.sv
// Shared types and helpers for the stream crossbar arbiter.
// Holds the per-master FSM state encoding and the round-robin pick function.
package crossbar_arbiter_pkg;

    localparam int unsigned RR_MAX   = 32;
    localparam int unsigned RR_IDX_W = 5;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of req[n-1:0], scanning ptr+1, ptr+2, ... modulo n.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] req,
                                         input int unsigned       n,
                                         input int unsigned       ptr);
        rr_pick_t    res;
        int unsigned cand;
        res = '0;
        for (int unsigned k = 1; k <= RR_MAX; k++) begin
            cand = (ptr + k) % n;
            if (!res.found && (k <= n) && req[cand[RR_IDX_W-1:0]]) begin
                res.found = 1'b1;
                res.idx   = RR_IDX_W'(cand);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/crossbar_arbiter_rr_master_arb.sv
// One master port's packet arbiter: round-robin pick in IDLE, hold the
// winning slave through its last beat in LOCKED, then release for one bubble.
module rr_master_arb
    import crossbar_arbiter_pkg::*;
#(
    parameter int unsigned S_CNT = 5,
    parameter int unsigned ID_W  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [S_CNT-1:0] req_i,
    input  logic [S_CNT-1:0] s_valid_i,
    input  logic [S_CNT-1:0] s_last_i,
    input  logic             m_ready_i,
    output logic [S_CNT-1:0] grant_c,
    output logic [S_CNT-1:0] ready_c,
    output logic             valid_c,
    output logic             last_c,
    output logic [ID_W-1:0]  owner_o
);

    arb_state_e      state_q, state_d;
    logic [ID_W-1:0] owner_q, owner_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    rr_pick_t        pick;
    logic            own_valid;
    logic            own_last;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        grant_c   = '0;
        ready_c   = '0;
        valid_c   = 1'b0;
        last_c    = 1'b0;
        own_valid = 1'b0;
        own_last  = 1'b0;
        pick      = rr_pick(RR_MAX'(req_i), S_CNT, 32'(ptr_q));

        for (int unsigned i = 0; i < S_CNT; i++) begin
            if (owner_q == ID_W'(i)) begin
                own_valid = s_valid_i[i];
                own_last  = s_last_i[i];
            end
        end

        case (state_q)
            ARB_IDLE: begin
                if (pick.found) begin
                    owner_d = ID_W'(pick.idx);
                    state_d = ARB_LOCKED;
                end
            end
            ARB_LOCKED: begin
                // Steering depends only on registered ownership, never on the pick.
                for (int unsigned i = 0; i < S_CNT; i++) begin
                    if (owner_q == ID_W'(i)) begin
                        grant_c[i] = 1'b1;
                        ready_c[i] = m_ready_i;
                    end
                end
                valid_c = own_valid;
                last_c  = own_last;
                if (own_valid && own_last && m_ready_i) begin
                    ptr_d   = owner_q;
                    state_d = ARB_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            ptr_q   <= ID_W'(S_CNT - 1);
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    assign owner_o = owner_q;

endmodule

// File: rtl/crossbar_arbiter.sv
// S x M stream switch control: decodes slave destinations into per-master
// requests, runs one packet arbiter per master and merges ready back to slaves.
module crossbar_arbiter
    import crossbar_arbiter_pkg::*;
#(
    parameter int unsigned S_DATA_COUNT = 5,
    parameter int unsigned M_DATA_COUNT = 3,
    parameter int unsigned T_ID___WIDTH = $clog2(S_DATA_COUNT),
    parameter int unsigned T_DEST_WIDTH = $clog2(M_DATA_COUNT)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [S_DATA_COUNT-1:0]              s_valid_i,
    input  logic [S_DATA_COUNT-1:0]              s_last_i,
    input  logic [S_DATA_COUNT*T_DEST_WIDTH-1:0] s_dest_i,
    output logic [S_DATA_COUNT-1:0]              s_ready_o,
    input  logic [M_DATA_COUNT-1:0]              m_ready_i,
    output logic [M_DATA_COUNT-1:0]              m_valid_o,
    output logic [M_DATA_COUNT-1:0]              m_last_o,
    output logic [M_DATA_COUNT*T_ID___WIDTH-1:0] m_id_o,
    output logic [S_DATA_COUNT*M_DATA_COUNT-1:0] grant_o
);

    localparam int unsigned S = S_DATA_COUNT;
    localparam int unsigned M = M_DATA_COUNT;

    logic [M*S-1:0] req_flat;
    logic [M*S-1:0] ready_flat;

    for (genvar j = 0; j < M; j++) begin : g_master
        // Out-of-range destinations never match, so such slaves are never served.
        for (genvar i = 0; i < S; i++) begin : g_req
            assign req_flat[j*S + i] = s_valid_i[i] &&
                (s_dest_i[i*T_DEST_WIDTH +: T_DEST_WIDTH] == T_DEST_WIDTH'(j));
        end

        rr_master_arb #(
            .S_CNT (S),
            .ID_W  (T_ID___WIDTH)
        ) u_arb (
            .clk       (clk),
            .rst_n     (rst_n),
            .req_i     (req_flat[j*S +: S]),
            .s_valid_i (s_valid_i),
            .s_last_i  (s_last_i),
            .m_ready_i (m_ready_i[j]),
            .grant_c   (grant_o[j*S +: S]),
            .ready_c   (ready_flat[j*S +: S]),
            .valid_c   (m_valid_o[j]),
            .last_c    (m_last_o[j]),
            .owner_o   (m_id_o[j*T_ID___WIDTH +: T_ID___WIDTH])
        );
    end

    always_comb begin
        s_ready_o = '0;
        for (int unsigned j = 0; j < M; j++) begin
            s_ready_o = s_ready_o | ready_flat[j*S +: S];
        end
    end

endmodule

// File: tb/tb_crossbar_arbiter.sv
// Directed and randomized checks of crossbar_arbiter against a per-master
// packet-ownership model driven by simple packet-producing slave sources.
module tb_crossbar_arbiter;

    localparam int S  = 5;
    localparam int M  = 3;
    localparam int IW = 3;
    localparam int DW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [S-1:0]  s_valid, s_last, s_ready;
    logic [S*DW-1:0] s_dest;
    logic [M-1:0]  m_ready, m_valid, m_last;
    logic [M*IW-1:0] m_id;
    logic [S*M-1:0]  grant;

    crossbar_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid_i (s_valid),
        .s_last_i  (s_last),
        .s_dest_i  (s_dest),
        .s_ready_o (s_ready),
        .m_ready_i (m_ready),
        .m_valid_o (m_valid),
        .m_last_o  (m_last),
        .m_id_o    (m_id),
        .grant_o   (grant)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: who owns each master, and who was served last
    int mdl_locked [M];
    int mdl_owner  [M];
    int mdl_ptr    [M];

    // slave packet sources
    int src_beats [S];
    int src_len   [S];
    int src_dest  [S];
    bit src_hold  [S];
    bit src_rep   [S];

    logic [S*M-1:0]  exp_grant, obs_grant;
    logic [S-1:0]    exp_ready, obs_ready;
    logic [M-1:0]    exp_valid, obs_valid, exp_last, obs_last;
    logic [M*IW-1:0] exp_id, obs_id;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < M; j++) begin
            mdl_locked[j] = 0;
            mdl_owner[j]  = 0;
            mdl_ptr[j]    = S - 1;
        end
    endtask

    task automatic load(input int i, input int len, input int dest, input bit rep);
        src_len[i]   = len;
        src_beats[i] = len;
        src_dest[i]  = dest;
        src_rep[i]   = rep;
        src_hold[i]  = 1'b0;
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < S; i++) begin
            s_valid[i] = (src_beats[i] > 0) && !src_hold[i];
            s_last[i]  = (src_beats[i] == 1);
            s_dest[i*DW +: DW] = DW'(src_dest[i]);
        end
    endtask

    task automatic model_outputs();
        int o;
        exp_grant = '0; exp_ready = '0; exp_valid = '0; exp_last = '0;
        for (int j = 0; j < M; j++) begin
            exp_id[j*IW +: IW] = IW'(mdl_owner[j]);
            if (mdl_locked[j] != 0) begin
                o = mdl_owner[j];
                exp_grant[j*S + o] = 1'b1;
                exp_valid[j] = s_valid[o];
                exp_last[j]  = s_last[o];
                if (m_ready[j]) exp_ready[o] = 1'b1;
            end
        end
    endtask

    task automatic model_step();
        int o;
        int cand;
        bit found;
        for (int i = 0; i < S; i++) begin
            if (s_valid[i] && exp_ready[i]) begin
                src_beats[i]--;
                if (src_beats[i] == 0 && src_rep[i]) src_beats[i] = src_len[i];
            end
        end
        for (int j = 0; j < M; j++) begin
            if (mdl_locked[j] != 0) begin
                o = mdl_owner[j];
                if (s_valid[o] && s_last[o] && m_ready[j]) begin
                    mdl_locked[j] = 0;
                    mdl_ptr[j]    = o;
                end
            end else begin
                found = 1'b0;
                for (int k = 1; k <= S; k++) begin
                    cand = (mdl_ptr[j] + k) % S;
                    if (!found && s_valid[cand] && (s_dest[cand*DW +: DW] == DW'(j))) begin
                        found         = 1'b1;
                        mdl_locked[j] = 1;
                        mdl_owner[j]  = cand;
                    end
                end
            end
        end
    endtask

    // One clock: inputs applied just after posedge, outputs checked at negedge.
    task automatic cycle();
        drive_inputs();
        @(negedge clk);
        model_outputs();
        obs_grant = grant; obs_ready = s_ready; obs_valid = m_valid;
        obs_last  = m_last; obs_id = m_id;
        chk("grant_o",   32'(obs_grant), 32'(exp_grant));
        chk("s_ready_o", 32'(obs_ready), 32'(exp_ready));
        chk("m_valid_o", 32'(obs_valid), 32'(exp_valid));
        chk("m_last_o",  32'(obs_last),  32'(exp_last));
        chk("m_id_o",    32'(obs_id),    32'(exp_id));
        @(posedge clk);
        if (rst_n) model_step();
        else model_reset();
        #1;
    endtask

    function automatic bit busy();
        for (int i = 0; i < S; i++) if (src_beats[i] > 0) return 1'b1;
        for (int j = 0; j < M; j++) if (mdl_locked[j] != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drain(input string tag);
        int n = 0;
        for (int i = 0; i < S; i++) begin src_rep[i] = 1'b0; src_hold[i] = 1'b0; end
        m_ready = '1;
        while (busy() && n < 200) begin cycle(); n++; end
        chk(tag, 32'(busy()), 32'(0));
        cycle();
    endtask

    int   g7 [5];
    int   order_q [$];
    int   exp_order [5] = '{0, 1, 4, 0, 1};
    logic [S-1:0] prev_row0;

    initial begin
        rst_n = 1'b0;
        m_ready = '0;
        for (int i = 0; i < S; i++) begin
            src_beats[i] = 0; src_len[i] = 0; src_dest[i] = 0;
            src_hold[i] = 1'b0; src_rep[i] = 1'b0;
        end
        model_reset();
        #1;
        cycle();
        cycle();
        rst_n = 1'b1;
        m_ready = '1;

        // idle after reset release
        repeat (10) cycle();

        // slave 2: 3-beat packet to master 1
        load(2, 3, 1, 1'b0);
        for (int c = 0; c < 5; c++) begin
            cycle();
            g7[c] = int'(obs_grant[7]);
            if (c == 1) chk("id_m1_owner", 32'(obs_id[1*IW +: IW]), 32'(2));
            if (c == 3) chk("last_m1_beat3", 32'(obs_last[1]), 32'(1));
        end
        for (int c = 0; c < 5; c++) chk("grant7_seq", 32'(g7[c]), 32'((c >= 1 && c <= 3) ? 1 : 0));

        // slaves 0,1,4 stream 2-beat packets into master 0
        load(0, 2, 0, 1'b1); load(1, 2, 0, 1'b1); load(4, 2, 0, 1'b1);
        prev_row0 = '0;
        for (int c = 0; c < 16; c++) begin
            cycle();
            if (obs_grant[S-1:0] != '0 && prev_row0 == '0) order_q.push_back(int'(obs_id[IW-1:0]));
            prev_row0 = obs_grant[S-1:0];
        end
        chk("rr_count", 32'(order_q.size() >= 5), 32'(1));
        for (int k = 0; k < 5; k++)
            if (k < order_q.size()) chk("rr_order", 32'(order_q[k]), 32'(exp_order[k]));
        drain("drain_rr");

        // slave 3 to master 2 with valid gaps and a 4-cycle stall; slave 0 competes
        load(3, 4, 2, 1'b0);
        cycle();
        cycle();
        src_hold[3] = 1'b1;
        load(0, 2, 2, 1'b0);
        cycle();
        cycle();
        chk("gap_hold_owner", 32'(obs_grant[2*S +: S]), 32'(5'b01000));
        src_hold[3] = 1'b0;
        m_ready[2] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            cycle();
            chk("stall_ready3", 32'(obs_ready[3]), 32'(0));
            chk("stall_owner", 32'(obs_id[2*IW +: IW]), 32'(3));
        end
        drain("drain_stall");

        // concurrent grants plus an unroutable destination
        load(0, 3, 0, 1'b0); load(1, 3, 2, 1'b0); load(4, 2, 3, 1'b0);
        for (int c = 0; c < 6; c++) begin
            cycle();
            if (c == 1) chk("concurrent", 32'({obs_grant[0], obs_grant[2*S + 1]}), 32'(2'b11));
            chk("bad_dest_ready4", 32'(obs_ready[4]), 32'(0));
            chk("bad_dest_grant4", 32'({obs_grant[4], obs_grant[S + 4], obs_grant[2*S + 4]}), 32'(0));
        end
        src_beats[4] = 0;
        drain("drain_conc");

        // reset during beat 2 of a 4-beat packet
        load(3, 4, 0, 1'b0);
        cycle();
        cycle();
        rst_n = 1'b0;
        model_reset();
        cycle();
        chk("rst_grant", 32'(obs_grant), 32'(0));
        chk("rst_ready", 32'(obs_ready), 32'(0));
        chk("rst_valid", 32'(obs_valid), 32'(0));
        src_beats[3] = 0;
        cycle();
        rst_n = 1'b1;
        load(3, 1, 0, 1'b0); load(0, 1, 0, 1'b0);
        cycle();
        cycle();
        chk("post_rst_winner", 32'(obs_grant[S-1:0]), 32'(5'b00001));
        drain("drain_rst");

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < S; i++) begin
                if (src_beats[i] == 0 && $urandom_range(3) == 0)
                    load(i, 1 + int'($urandom_range(3)), int'($urandom_range(2)), 1'b0);
                src_hold[i] = ($urandom_range(3) == 0);
            end
            for (int j = 0; j < M; j++) m_ready[j] = ($urandom_range(3) != 0);
            cycle();
        end
        drain("drain_rand");

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

endmodule
